// File: rtl/fastkdf_ctrl.sv
// FastKDF round controller: walks the B buffer with a PRF for ROUNDS rounds.
// Optional debug ports (round count, FSM state) are enabled with `define FASTKDF_DBG_EN.
module fastkdf_ctrl #(
  parameter int PASSWD_LEN   = 80,
  parameter int KDF_BUF_SIZE = 256,
  parameter int INPUT_SIZE   = 64,
  parameter int KEY_SIZE     = 32,
  parameter int OUTPUT_SIZE  = 32,
  parameter int ROUNDS       = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_vld,
  output logic                                  in_rdy,
  input  logic [(KDF_BUF_SIZE+INPUT_SIZE)*8-1:0] a_in,
  input  logic [(KDF_BUF_SIZE+KEY_SIZE)*8-1:0]   b_in,
  input  logic [7:0]                            buf_ptr_in,
  input  logic [PASSWD_LEN*8-1:0]               password,
  output logic                                  req_vld,
  input  logic                                  req_rdy,
  output logic [INPUT_SIZE*8-1:0]               prf_input,
  output logic [KEY_SIZE*8-1:0]                 prf_key,
  input  logic                                  rsp_vld,
  output logic                                  rsp_rdy,
  input  logic [OUTPUT_SIZE*8-1:0]              prf_output,
  output logic                                  out_vld,
  input  logic                                  out_rdy,
  output logic [(KDF_BUF_SIZE+INPUT_SIZE)*8-1:0] a_out,
  output logic [(KDF_BUF_SIZE+KEY_SIZE)*8-1:0]   b_out,
  output logic [7:0]                            buf_ptr_out,
  output logic [PASSWD_LEN*8-1:0]               password_o
`ifdef FASTKDF_DBG_EN
  ,
  output logic [7:0]                            dbg_rnd,
  output logic [2:0]                            dbg_state
`endif
);

  localparam int A_W   = (KDF_BUF_SIZE + INPUT_SIZE) * 8;
  localparam int B_W   = (KDF_BUF_SIZE + KEY_SIZE) * 8;
  localparam int SUM_W = 8 + $clog2(OUTPUT_SIZE) + 1;
  localparam logic [7:0] PTR_MASK = 8'(KDF_BUF_SIZE - 1);
  localparam logic [7:0] ROUNDS_B = 8'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_UPD  = 3'd3,
    S_MIRR = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; every valid/ready driven here is a flop, so no input reaches them combinationally.
  state_t                   state_q, state_d;
  logic [7:0]               ptr_q, ptr_d;
  logic [7:0]               ptr_next_q, ptr_next_d;
  logic [7:0]               rnd_q, rnd_d;
  logic [A_W-1:0]           a_q, a_d;
  logic [B_W-1:0]           b_q, b_d;
  logic [PASSWD_LEN*8-1:0]  pw_q, pw_d;
  logic [OUTPUT_SIZE*8-1:0] out_q, out_d;
  logic [SUM_W-1:0]         sum;
  logic in_rdy_q, in_rdy_d;
  logic req_vld_q, req_vld_d;
  logic rsp_rdy_q, rsp_rdy_d;
  logic out_vld_q, out_vld_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ptr_next_d = ptr_next_q;
    rnd_d      = rnd_q;
    a_d        = a_q;
    b_d        = b_q;
    pw_d       = pw_q;
    out_d      = out_q;
    sum        = '0;
    case (state_q)
      S_IDLE: begin
        if (in_vld && in_rdy_q) begin
          a_d     = a_in;
          b_d     = b_in;
          pw_d    = password;
          ptr_d   = buf_ptr_in & PTR_MASK;
          rnd_d   = 8'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (req_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_vld) begin
          out_d   = prf_output;
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        // XOR lands in the head only; the tail copy is refreshed next cycle.
        for (int k = 0; k < OUTPUT_SIZE; k++) begin
          b_d[((int'(ptr_q) + k) % KDF_BUF_SIZE) * 8 +: 8] =
            b_q[((int'(ptr_q) + k) % KDF_BUF_SIZE) * 8 +: 8] ^ out_q[k*8 +: 8];
          sum = sum + SUM_W'(out_q[k*8 +: 8]);
        end
        ptr_next_d = 8'(sum % SUM_W'(KDF_BUF_SIZE));
        state_d    = S_MIRR;
      end
      S_MIRR: begin
        for (int i = 0; i < KEY_SIZE; i++) begin
          b_d[(KDF_BUF_SIZE + i) * 8 +: 8] = b_q[i*8 +: 8];
        end
        ptr_d   = ptr_next_q;
        rnd_d   = rnd_q + 8'd1;
        state_d = (rnd_d < ROUNDS_B) ? S_REQ : S_DONE;
      end
      S_DONE: begin
        if (out_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_rdy_d  = (state_d == S_IDLE);
    req_vld_d = (state_d == S_REQ);
    rsp_rdy_d = (state_d == S_WAIT);
    out_vld_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 8'd0;
      rnd_q     <= 8'd0;
      in_rdy_q  <= 1'b1;
      req_vld_q <= 1'b0;
      rsp_rdy_q <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rnd_q     <= rnd_d;
      in_rdy_q  <= in_rdy_d;
      req_vld_q <= req_vld_d;
      rsp_rdy_q <= rsp_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q        <= a_d;
    b_q        <= b_d;
    pw_q       <= pw_d;
    out_q      <= out_d;
    ptr_next_q <= ptr_next_d;
  end

  assign in_rdy      = in_rdy_q;
  assign req_vld     = req_vld_q;
  assign rsp_rdy     = rsp_rdy_q;
  assign out_vld     = out_vld_q;
  assign prf_input   = a_q[int'(ptr_q) * 8 +: INPUT_SIZE * 8];
  assign prf_key     = b_q[int'(ptr_q) * 8 +: KEY_SIZE * 8];
  assign a_out       = a_q;
  assign b_out       = b_q;
  assign buf_ptr_out = ptr_q;
  assign password_o  = pw_q;

`ifdef FASTKDF_DBG_EN
  assign dbg_rnd   = rnd_q;
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_fastkdf_ctrl.sv
// Bench for fastkdf_ctrl: random and directed jobs checked against a byte-array FastKDF model.
module tb_fastkdf_ctrl;
  localparam int N  = 256;
  localparam int IS = 64;
  localparam int KS = 32;
  localparam int OS = 32;
  localparam int PL = 80;
  localparam int R  = 32;
  localparam int AW = (N + IS) * 8;
  localparam int BW = (N + KS) * 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_vld, in_rdy;
  logic [AW-1:0]   a_in, a_out;
  logic [BW-1:0]   b_in, b_out;
  logic [7:0]      buf_ptr_in, buf_ptr_out;
  logic [PL*8-1:0] password, password_o;
  logic            req_vld, req_rdy;
  logic [IS*8-1:0] prf_input;
  logic [KS*8-1:0] prf_key;
  logic            rsp_vld, rsp_rdy;
  logic [OS*8-1:0] prf_output;
  logic            out_vld, out_rdy;
`ifdef FASTKDF_DBG_EN
  logic [7:0]      dbg_rnd;
  logic [2:0]      dbg_state;
`endif

  always #5 clk = ~clk;

  fastkdf_ctrl dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .a_in(a_in), .b_in(b_in), .buf_ptr_in(buf_ptr_in), .password(password),
    .req_vld(req_vld), .req_rdy(req_rdy), .prf_input(prf_input), .prf_key(prf_key),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .prf_output(prf_output),
    .out_vld(out_vld), .out_rdy(out_rdy), .a_out(a_out), .b_out(b_out),
    .buf_ptr_out(buf_ptr_out), .password_o(password_o)
`ifdef FASTKDF_DBG_EN
    , .dbg_rnd(dbg_rnd), .dbg_state(dbg_state)
`endif
  );

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int out_cnt = 0;
  logic [BW-1:0] exp_q[$];

  // Reference state: plain byte arrays
  logic [7:0] a_m[N+IS];
  logic [7:0] b_m[N+KS];
  int ptr_m;

  always @(posedge clk) begin
    if (!rst && req_vld && req_rdy) hs_cnt++;
    if (!rst && out_vld && out_rdy) out_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_data(input bit zero_b);
    for (int i = 0; i < N + IS; i++) a_m[i] = 8'($urandom);
    for (int i = 0; i < N + KS; i++) b_m[i] = zero_b ? 8'h00 : 8'($urandom);
  endtask

  // prf_mode: 0 random bytes, 1 all 0x01, 2 all 0xFF
  task automatic run_job(input logic [7:0] ptr0, input int prf_mode, input int max_bp,
                         input int hold, input bit expect_immediate);
    logic [AW-1:0]   av;
    logic [BW-1:0]   bv;
    logic [BW-1:0]   expb;
    logic [PL*8-1:0] pw;
    logic [IS*8-1:0] ein;
    logic [KS*8-1:0] ekey;
    logic [OS*8-1:0] o;
    int cnt, lat, d, s, hs0, bad;
    for (int i = 0; i < N + IS; i++) av[i*8 +: 8] = a_m[i];
    for (int i = 0; i < N + KS; i++) bv[i*8 +: 8] = b_m[i];
    for (int i = 0; i < PL; i++) pw[i*8 +: 8] = 8'($urandom);
    cnt = 0;
    while (!in_rdy && cnt < 50) begin step(); cnt++; end
    if (expect_immediate) begin
      checks++;
      if (cnt !== 0) begin errors++; $display("FAIL accept_next_cycle waited %0d cycles, required 0", cnt); end
    end
    if (!in_rdy) begin
      errors++; $display("FAIL in_rdy_timeout got 0 required 1"); return;
    end
    in_vld = 1'b1; a_in = av; b_in = bv; password = pw; buf_ptr_in = ptr0;
    step();
    in_vld = 1'b0; a_in = ~av; b_in = ~bv; password = ~pw; buf_ptr_in = ~ptr0;
    ptr_m = int'(ptr0) % N;
    hs0 = hs_cnt;
    for (int r = 0; r < R; r++) begin
      lat = 0;
      while (!req_vld && lat < 50) begin step(); lat++; end
      checks++;
      if (lat !== (r == 0 ? 0 : 2)) begin
        errors++; $display("FAIL req_latency r=%0d got %0d required %0d", r, lat, (r == 0 ? 0 : 2));
      end
      if (!req_vld) begin errors++; $display("FAIL req_timeout r=%0d", r); return; end
      for (int i = 0; i < IS; i++) ein[i*8 +: 8] = a_m[ptr_m + i];
      for (int i = 0; i < KS; i++) ekey[i*8 +: 8] = b_m[ptr_m + i];
      checks++;
      if (prf_input !== ein) begin errors++; $display("FAIL prf_input r=%0d got %h required %h", r, prf_input, ein); end
      checks++;
      if (prf_key !== ekey) begin errors++; $display("FAIL prf_key r=%0d got %h required %h", r, prf_key, ekey); end
      // Stray responses while a request is pending must be ignored
      d = $urandom_range(0, max_bp);
      repeat (d) begin
        rsp_vld = 1'b1;
        for (int k = 0; k < OS; k++) prf_output[k*8 +: 8] = 8'($urandom);
        step();
      end
      rsp_vld = 1'b0;
      checks++;
      if (req_vld !== 1'b1 || prf_key !== ekey || rsp_rdy !== 1'b0) begin
        errors++; $display("FAIL req_hold r=%0d req_vld=%b rsp_rdy=%b required 1/0 key stable", r, req_vld, rsp_rdy);
      end
      req_rdy = 1'b1;
      step();
      req_rdy = 1'b0;
      d = $urandom_range(0, max_bp);
      repeat (d) step();
      checks++;
      if (req_vld !== 1'b0 || rsp_rdy !== 1'b1) begin
        errors++; $display("FAIL wait_state r=%0d req_vld=%b rsp_rdy=%b required 0/1", r, req_vld, rsp_rdy);
      end
      for (int k = 0; k < OS; k++) begin
        case (prf_mode)
          1:       o[k*8 +: 8] = 8'h01;
          2:       o[k*8 +: 8] = 8'hFF;
          default: o[k*8 +: 8] = 8'($urandom);
        endcase
      end
      rsp_vld = 1'b1; prf_output = o;
      step();
      rsp_vld = 1'b0;
      s = 0;
      for (int k = 0; k < OS; k++) begin
        b_m[(ptr_m + k) % N] = b_m[(ptr_m + k) % N] ^ o[k*8 +: 8];
        s += int'(o[k*8 +: 8]);
      end
      for (int i = 0; i < KS; i++) b_m[N + i] = b_m[i];
      ptr_m = s % N;
    end
    lat = 0;
    while (!out_vld && lat < 50) begin step(); lat++; end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL done_latency got %0d required 2", lat); end
    for (int i = 0; i < N + KS; i++) expb[i*8 +: 8] = b_m[i];
    exp_q.push_back(expb);
    checks++;
    if (hs_cnt - hs0 !== R || req_vld !== 1'b0) begin
      errors++; $display("FAIL req_handshakes got %0d required %0d", hs_cnt - hs0, R);
    end
    checks++;
    bad = -1;
    for (int i = N + KS - 1; i >= 0; i--) if (b_out[i*8 +: 8] !== expb[i*8 +: 8]) bad = i;
    if (bad >= 0) begin
      errors++; $display("FAIL b_out byte %0d got %h required %h", bad, b_out[bad*8 +: 8], expb[bad*8 +: 8]);
    end
    void'(exp_q.pop_front());
    checks++;
    if (buf_ptr_out !== 8'(ptr_m)) begin errors++; $display("FAIL buf_ptr_out got %0d required %0d", buf_ptr_out, ptr_m); end
    checks++;
    if (a_out !== av || password_o !== pw) begin errors++; $display("FAIL a_out_password got changed required captured values"); end
    for (int c = 0; c < hold; c++) begin
      step();
      checks++;
      if (out_vld !== 1'b1 || in_rdy !== 1'b0 || b_out !== expb || buf_ptr_out !== 8'(ptr_m)) begin
        errors++; $display("FAIL done_hold c=%0d out_vld=%b in_rdy=%b required 1/0 with stable outputs", c, out_vld, in_rdy);
      end
    end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      errors++; $display("FAIL release out_vld=%b in_rdy=%b required 0/1", out_vld, in_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b0; req_rdy = 1'b0; rsp_vld = 1'b0; out_rdy = 1'b0;
    a_in = '0; b_in = '0; buf_ptr_in = '0; password = '0; prf_output = '0;
    repeat (3) step();
    rst = 1'b0;
    checks++;
    if (in_rdy !== 1'b1 || req_vld !== 1'b0 || rsp_rdy !== 1'b0 || out_vld !== 1'b0 || buf_ptr_out !== 8'd0) begin
      errors++; $display("FAIL reset_state in_rdy=%b req_vld=%b rsp_rdy=%b out_vld=%b ptr=%0d required 1/0/0/0/0",
                         in_rdy, req_vld, rsp_rdy, out_vld, buf_ptr_out);
    end
  endtask

  task automatic test_zero_fill();
    fill_data(1'b1);
    run_job(8'd0, 1, 2, 0, 1'b0);
  endtask

  task automatic test_wrap();
    fill_data(1'b0);
    run_job(8'd240, 2, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) begin
      fill_data(1'b0);
      run_job(8'($urandom), 0, 5, 0, 1'b0);
    end
  endtask

  task automatic test_done_hold();
    fill_data(1'b0);
    run_job(8'($urandom), 0, 3, 10, 1'b0);
    fill_data(1'b0);
    run_job(8'($urandom), 0, 1, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    fill_data(1'b0);
    run_job(8'($urandom), 0, 0, 0, 1'b0);
    fill_data(1'b0);
    run_job(8'($urandom), 0, 0, 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    int cnt, hs0, out0, seen;
    fill_data(1'b0);
    for (int i = 0; i < N + IS; i++) a_in[i*8 +: 8] = a_m[i];
    for (int i = 0; i < N + KS; i++) b_in[i*8 +: 8] = b_m[i];
    buf_ptr_in = 8'($urandom);
    in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    cnt = 0;
    while (!req_vld && cnt < 50) begin step(); cnt++; end
    req_rdy = 1'b1;
    step();
    req_rdy = 1'b0;
    rsp_vld = 1'b1; prf_output = {OS{8'h5A}}; rst = 1'b1;
    step();
    rst = 1'b0; rsp_vld = 1'b0;
    checks++;
    if (in_rdy !== 1'b1 || req_vld !== 1'b0 || out_vld !== 1'b0 || rsp_rdy !== 1'b0 || buf_ptr_out !== 8'd0) begin
      errors++; $display("FAIL mid_reset in_rdy=%b req_vld=%b out_vld=%b rsp_rdy=%b ptr=%0d required 1/0/0/0/0",
                         in_rdy, req_vld, out_vld, rsp_rdy, buf_ptr_out);
    end
    hs0 = hs_cnt; out0 = out_cnt; seen = 0;
    req_rdy = 1'b1; out_rdy = 1'b1;
    repeat (10) begin
      step();
      if (req_vld || out_vld || !in_rdy) seen++;
    end
    req_rdy = 1'b0; out_rdy = 1'b0;
    checks++;
    if (seen !== 0 || hs_cnt !== hs0 || out_cnt !== out0) begin
      errors++; $display("FAIL abandon_job activity=%0d req_hs=%0d out_hs=%0d required 0/0/0",
                         seen, hs_cnt - hs0, out_cnt - out0);
    end
    fill_data(1'b0);
    run_job(8'($urandom), 0, 2, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_zero_fill();
    test_wrap();
    test_random();
    test_done_hold();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
